// File: rtl/code_pkg.sv
// Shared state encoding and symbol layout for the colour-code sender and its scan counter.
package code_pkg;

  localparam int SYM_W     = 3;
  localparam int RED_BIT   = 2;
  localparam int GREEN_BIT = 1;
  localparam int BLUE_BIT  = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRST  = 3'd1,
    S_WAIT  = 3'd2,
    S_START = 3'd3,
    S_SYM   = 3'd4,
    S_CHECK = 3'd5,
    S_DONE  = 3'd6
  } state_t;

endpackage

// File: rtl/code_sender_if.sv
// Request, detector-drive and status bundle of code_sender.
// Scan, Found and Found_Code exist only when CODE_SENDER_SCAN_EN is defined.
interface code_sender_if #(
  parameter int NUM_SYMBOLS = 4
);
  localparam int CODE_W = code_pkg::SYM_W * NUM_SYMBOLS;

  logic              Send;
  logic [CODE_W-1:0] Code;
  logic              U;
  logic              Det_Rst;
  logic              Start;
  logic              Red;
  logic              Green;
  logic              Blue;
  logic              Busy;
  logic              Done;
  logic              Pass;
`ifdef CODE_SENDER_SCAN_EN
  logic              Scan;
  logic              Found;
  logic [CODE_W-1:0] Found_Code;
`endif

  // master: requester plus detector side; slave: the sender itself
  modport master (
    output Send, Code, U,
`ifdef CODE_SENDER_SCAN_EN
    output Scan,
    input  Found, Found_Code,
`endif
    input  Det_Rst, Start, Red, Green, Blue, Busy, Done, Pass
  );

  modport slave (
    input  Send, Code, U,
`ifdef CODE_SENDER_SCAN_EN
    input  Scan,
    output Found, Found_Code,
`endif
    output Det_Rst, Start, Red, Green, Blue, Busy, Done, Pass
  );

endinterface

// File: rtl/code_scan_counter.sv
// Candidate code register for the exhaustive scan: clear, increment, terminal-count flag.
module code_scan_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] value,
  output logic         last
);

  logic [W-1:0] cnt_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (clr) begin
      cnt_r <= '0;
    end else if (inc) begin
      cnt_r <= cnt_r + W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign value = cnt_r;
  assign last  = &cnt_r;

endmodule

// File: rtl/code_sender.sv
// Drives a colour-code detector through reset, start and NUM_SYMBOLS symbols, then reports U.
// Optional exhaustive code search is compiled in with CODE_SENDER_SCAN_EN.
module code_sender
  import code_pkg::*;
#(
  parameter int NUM_SYMBOLS = 4
) (
  input  logic         Clk,
  input  logic         Rst,
  code_sender_if.slave bus
);

  localparam int CODE_W = SYM_W * NUM_SYMBOLS;
  localparam int IDX_W  = (NUM_SYMBOLS > 1) ? $clog2(NUM_SYMBOLS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SYMBOLS - 1);

  state_t            state_r, state_s;
  logic [IDX_W-1:0]  idx_r, idx_s;
  logic              req_r;
  logic [CODE_W-1:0] code_r;
  logic [CODE_W-1:0] sym_code_s;
  logic              scan_s;
  logic              retry_s;
  logic              det_rst_r, start_r, busy_r, done_r, pass_r;
  logic [SYM_W-1:0]  rgb_r;

  function automatic logic [SYM_W-1:0] sym_at(input logic [CODE_W-1:0] c,
                                              input logic [IDX_W-1:0]  i);
    logic [CODE_W-1:0] sh;
    sh = c >> (SYM_W * int'(i));
    return sh[SYM_W-1:0];
  endfunction

`ifdef CODE_SENDER_SCAN_EN
  logic              scan_req_r, scanning_r, found_r;
  logic [CODE_W-1:0] cand_s, found_code_r;
  logic              cand_last_s, cand_clr_s;

  assign scan_s     = bus.Scan;
  assign cand_clr_s = (state_r == S_IDLE) && req_r && scan_req_r;
  assign retry_s    = (state_r == S_CHECK) && scanning_r && !bus.U && !cand_last_s;
  assign sym_code_s = scanning_r ? cand_s : code_r;

  code_scan_counter #(.W(CODE_W)) u_cand (
    .clk   (Clk),
    .rst_n (Rst),
    .clr   (cand_clr_s),
    .inc   (retry_s),
    .value (cand_s),
    .last  (cand_last_s)
  );

  // Scan mode flag and result capture; Send wins over Scan in the same cycle
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      scan_req_r   <= 1'b0;
      scanning_r   <= 1'b0;
      found_r      <= 1'b0;
      found_code_r <= '0;
    end else begin
      if (state_s == S_IDLE) begin
        scan_req_r <= bus.Scan & ~bus.Send;
      end else begin
        scan_req_r <= 1'b0;
      end
      if ((state_r == S_IDLE) && req_r) begin
        scanning_r <= scan_req_r;
      end else begin
        scanning_r <= scanning_r;
      end
      if (cand_clr_s) begin
        found_r      <= 1'b0;
        found_code_r <= '0;
      end else if ((state_r == S_CHECK) && scanning_r && bus.U) begin
        found_r      <= 1'b1;
        found_code_r <= cand_s;
      end else begin
        found_r      <= found_r;
        found_code_r <= found_code_r;
      end
    end
  end

  assign bus.Found      = found_r;
  assign bus.Found_Code = found_code_r;
`else
  assign scan_s     = 1'b0;
  assign retry_s    = 1'b0;
  assign sym_code_s = code_r;
`endif

  // Requests are taken on every edge that lands in IDLE, so a held Send
  // restarts after exactly one idle cycle and Code is frozen from then on.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      req_r  <= 1'b0;
      code_r <= '0;
    end else if (state_s == S_IDLE) begin
      req_r <= bus.Send | scan_s;
      if (bus.Send) begin
        code_r <= bus.Code;
      end else begin
        code_r <= code_r;
      end
    end else begin
      req_r  <= 1'b0;
      code_r <= code_r;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_r <= S_IDLE;
      idx_r   <= '0;
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
    end
  end

  always_comb begin
    state_s = state_r;
    idx_s   = idx_r;
    case (state_r)
      S_IDLE: begin
        if (req_r) begin
          state_s = S_DRST;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_DRST:  state_s = S_WAIT;
      S_WAIT:  state_s = S_START;
      S_START: begin
        state_s = S_SYM;
        idx_s   = '0;
      end
      S_SYM: begin
        if (idx_r == LAST_IDX) begin
          state_s = S_CHECK;
          idx_s   = idx_r;
        end else begin
          state_s = S_SYM;
          idx_s   = idx_r + IDX_W'(1);
        end
      end
      S_CHECK: begin
        if (retry_s) begin
          state_s = S_DRST;
        end else begin
          state_s = S_DONE;
        end
      end
      S_DONE:  state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track state_r exactly;
  // U is taken on the edge that leaves CHECK, after the last symbol settled.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      det_rst_r <= 1'b0;
      start_r   <= 1'b0;
      rgb_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
    end else begin
      det_rst_r <= (state_s == S_DRST);
      start_r   <= (state_s == S_START);
      rgb_r     <= (state_s == S_SYM) ? sym_at(sym_code_s, idx_s) : SYM_W'(0);
      busy_r    <= (state_s != S_IDLE);
      done_r    <= (state_s == S_DONE);
      if (state_r == S_CHECK) begin
        pass_r <= bus.U;
      end else begin
        pass_r <= pass_r;
      end
    end
  end

  assign bus.Det_Rst = det_rst_r;
  assign bus.Start   = start_r;
  assign bus.Red     = rgb_r[RED_BIT];
  assign bus.Green   = rgb_r[GREEN_BIT];
  assign bus.Blue    = rgb_r[BLUE_BIT];
  assign bus.Busy    = busy_r;
  assign bus.Done    = done_r;
  assign bus.Pass    = pass_r;

endmodule

// File: doc/code_sender.md
# code_sender

Sequence generator that drives a colour-code detector's Start/Red/Green/Blue inputs and reads back its unlock flag U. On a Send request it resets the detector, issues the Start pulse, and plays NUM_SYMBOLS colour symbols one per clock. It then samples U and reports pass/fail. It sits next to the code detector as its initiator, for board-level self-test and automated entry.

## Interface
- NUM_SYMBOLS, 4: symbols per code.
- CODE_W, 3*NUM_SYMBOLS: derived code width; not overridable.
- Clk  input  1  system clock; all state changes on the rising edge.
- Rst  input  1  asynchronous, active-low reset.
- Send  input  1  request to transmit Code; sampled only in IDLE.
- Code  input  CODE_W  symbol i occupies Code[3i+2:3i] as {Red,Green,Blue}; symbol 0 is sent first.
- U  input  1  unlock flag from the detector.
- Det_Rst  output  1  active-high reset to the detector.
- Start  output  1  start pulse to the detector.
- Red, Green, Blue  output  1 each  current symbol bits.
- Busy  output  1  high in every state except IDLE.
- Done  output  1  one-cycle completion pulse.
- Pass  output  1  U value captured in CHECK; held until the next Done.

## Operation
- All outputs are registered Moore outputs decoded from the next state.
- FSM states:
  - IDLE: all drive outputs 0. Send=1 latches Code into code_q and moves to DRST.
  - DRST: Det_Rst=1 for one cycle, then WAIT.
  - WAIT: all outputs 0 for one cycle, then START.
  - START: Start=1 for one cycle; clear symbol index idx. Then SYM.
  - SYM: {Red,Green,Blue} = code_q[3*idx+2 -: 3] and Start=0. idx increments each cycle. When idx==NUM_SYMBOLS-1, go to CHECK.
  - CHECK: drive outputs 0; sample U into Pass. Then DONE.
  - DONE: Done=1 for one cycle, then IDLE.
- Send while Busy is ignored and not queued. Code changes while Busy have no effect, because code_q is latched.
- Send held high across DONE→IDLE starts a new transaction on the first IDLE cycle.
- idx width is $clog2(NUM_SYMBOLS). No wrap beyond NUM_SYMBOLS-1.
- At most one of Det_Rst, Start, or a nonzero colour is active in any cycle.

## Timing
- Reset values: Det_Rst, Start, Red, Green, Blue, Busy, Done, Pass all 0. FSM in IDLE, idx=0, code_q=0.
- Reset assertion mid-transaction forces every output to 0 immediately, without waiting for a clock edge.
- Send sampled high at edge k gives:
  - Det_Rst high after edge k+1.
  - Start high after edge k+3.
  - Symbol i on Red/Green/Blue after edge k+4+i.
  - CHECK after edge k+4+NUM_SYMBOLS. U is sampled at edge k+5+NUM_SYMBOLS.
  - Done and Pass valid after edge k+5+NUM_SYMBOLS.
- Default NUM_SYMBOLS=4 takes 10 cycles from the Send edge to Done, inclusive of the Done cycle.
- Busy rises after edge k+1 and falls with the edge that leaves DONE.

## Configuration
- CODE_SENDER_SCAN_EN defined:
  - Adds input Scan (1 bit) and outputs Found (1 bit) and Found_Code (CODE_W).
  - Scan=1 in IDLE starts an exhaustive search with candidate=0. Each candidate runs the full DRST…CHECK sequence.
  - CHECK with U=1: Found=1, Found_Code=candidate, Pass=1, go to DONE.
  - CHECK with U=0: candidate+1, back to DRST.
  - Candidate at 2^CODE_W−1 failing: DONE with Pass=0, Found=0.
  - Send has priority over Scan when both are high in IDLE.
  - Found and Found_Code reset to 0 and clear at the start of each new scan.
- CODE_SENDER_SCAN_EN undefined: none of these ports, nor the candidate counter, exist. Behaviour is exactly as described above.

## Structure
- Shared package code_pkg:
  - State enum.
  - SYM_W=3.
  - Bit positions RED_BIT=2, GREEN_BIT=1, BLUE_BIT=0.
- One natural sub-module, code_scan_counter: candidate register with clear, increment and terminal-count flag. It is instantiated only under CODE_SENDER_SCAN_EN.

## Test plan
- Reset mid-SYM: all outputs 0 immediately. After release, FSM is in IDLE and Busy=0.
- Send with Code=12'h88C (Red,Blue,Green,Red) against a detector model: colours 100,001,010,100 after edges k+4..k+7. U=1 gives Done with Pass=1 after edge k+9.
- Send with Code=12'h000: Pass=0, Done pulses exactly one cycle, Busy=0 after it.
- Send pulsed again during SYM: ignored, one Done only. Send held high gives back-to-back transactions separated by a single IDLE cycle.
- Code changed to 12'hFFF one cycle after Send: transmitted symbols still match the latched 12'h88C.
- With CODE_SENDER_SCAN_EN: Scan=1 against a detector keyed 12'h88C ends with Found=1, Found_Code=12'h88C, Pass=1 after 2189 attempts. With an always-failing detector it ends with Found=0 after 4096 attempts.
